// File: rtl/commit_stage_if.sv
// Shared types for the retirement path and the commit-stage bus bundle.
// The scoreboard head, GPR write port, store-buffer commit, CSR commit, trap and flush signals travel together.
package config_pkg;
    localparam int unsigned XLEN = 64;

    typedef enum logic [2:0] {
        FU_ALU    = 3'd0,
        FU_BRANCH = 3'd1,
        FU_LOAD   = 3'd2,
        FU_STORE  = 3'd3,
        FU_MULT   = 3'd4,
        FU_CSR    = 3'd5,
        FU_FENCE  = 3'd6
    } fu_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
    } exception_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        fu_t             fu;
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
        exception_t      ex;
    } scoreboard_entry_t;
endpackage

interface commit_stage_if #(
    parameter int unsigned XLEN = config_pkg::XLEN
);
    import config_pkg::*;

    logic              halt_i;
    scoreboard_entry_t commit_instr_i;
    logic              commit_ack_o;
    logic              we_gpr_o;
    logic [4:0]        waddr_o;
    logic [XLEN-1:0]   wdata_o;
    logic              commit_lsu_o;
    logic              commit_lsu_ready_i;
    logic              csr_commit_o;
    logic [XLEN-1:0]   csr_rdata_i;
    logic              exception_o;
    logic [XLEN-1:0]   ex_cause_o;
    logic [XLEN-1:0]   ex_tval_o;
    logic [XLEN-1:0]   ex_pc_o;
    logic              flush_o;
    logic [XLEN-1:0]   flush_pc_o;
    logic [63:0]       instret_o;

    // The commit stage itself.
    modport master (
        input  halt_i, commit_instr_i, commit_lsu_ready_i, csr_rdata_i,
        output commit_ack_o, we_gpr_o, waddr_o, wdata_o, commit_lsu_o,
               csr_commit_o, exception_o, ex_cause_o, ex_tval_o, ex_pc_o,
               flush_o, flush_pc_o, instret_o
    );

    // Scoreboard, register file, LSU, CSR file and controller side.
    modport slave (
        output halt_i, commit_instr_i, commit_lsu_ready_i, csr_rdata_i,
        input  commit_ack_o, we_gpr_o, waddr_o, wdata_o, commit_lsu_o,
               csr_commit_o, exception_o, ex_cause_o, ex_tval_o, ex_pc_o,
               flush_o, flush_pc_o, instret_o
    );
endinterface

// File: rtl/commit_stage.sv
// In-order, single-issue retirement of the scoreboard head. Retirement side effects are combinational
// so the scoreboard pops on the same edge; traps, flushes and the instret counter are registered.
module commit_stage
    import config_pkg::*;
#(
    parameter int unsigned XLEN = config_pkg::XLEN
) (
    input  logic           clk_i,
    input  logic           rst_i,
    commit_stage_if.master bus
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    state_t            state_q;
    logic              flush_q;
    logic [XLEN-1:0]   flush_pc_q;
    logic              exception_q;
    logic [XLEN-1:0]   ex_cause_q;
    logic [XLEN-1:0]   ex_tval_q;
    logic [XLEN-1:0]   ex_pc_q;
    logic [63:0]       instret_q;

    scoreboard_entry_t head;
    logic              head_eligible;
    logic              ack;
    logic              we_gpr;
    logic [4:0]        waddr;
    logic [XLEN-1:0]   wdata;
    logic              lsu_commit;
    logic              csr_commit;
    logic              retire;

    assign head          = bus.commit_instr_i;
    assign head_eligible = (state_q == RUN) && head.valid && !bus.halt_i && !rst_i;
    // Excepting entries are acknowledged but do not count as retired instructions.
    assign retire        = ack && !head.ex.valid;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no inferred latch).
        ack        = 1'b0;
        we_gpr     = 1'b0;
        waddr      = '0;
        wdata      = '0;
        lsu_commit = 1'b0;
        csr_commit = 1'b0;

        case (state_q)
            RUN: begin
                if (head_eligible) begin
                    if (head.ex.valid) begin
                        ack = 1'b1;
                    end else begin
                        case (head.fu)
                            FU_ALU, FU_BRANCH, FU_LOAD, FU_MULT: begin
                                ack    = 1'b1;
                                we_gpr = (head.rd != 5'd0);
                                if (we_gpr) begin
                                    waddr = head.rd;
                                    wdata = head.result;
                                end
                            end
                            FU_STORE: begin
                                lsu_commit = 1'b1;
                                ack        = bus.commit_lsu_ready_i;
                            end
                            FU_CSR: begin
                                csr_commit = 1'b1;
                                ack        = 1'b1;
                                we_gpr     = (head.rd != 5'd0);
                                if (we_gpr) begin
                                    waddr = head.rd;
                                    wdata = bus.csr_rdata_i;
                                end
                            end
                            FU_FENCE: begin
                                ack = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            // The store stays pending regardless of halt; reset withdraws the request at once.
            STORE_WAIT: begin
                if (!rst_i) begin
                    lsu_commit = 1'b1;
                    ack        = bus.commit_lsu_ready_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst_i) begin
            state_q     <= RUN;
            flush_q     <= 1'b0;
            flush_pc_q  <= '0;
            exception_q <= 1'b0;
            ex_cause_q  <= '0;
            ex_tval_q   <= '0;
            ex_pc_q     <= '0;
            instret_q   <= '0;
        end else begin
            exception_q <= 1'b0;
            flush_q     <= 1'b0;
            if (retire) begin
                instret_q <= instret_q + 64'd1;
            end

            case (state_q)
                RUN: begin
                    if (head_eligible) begin
                        if (head.ex.valid) begin
                            exception_q <= 1'b1;
                            ex_cause_q  <= head.ex.cause;
                            ex_tval_q   <= head.ex.tval;
                            ex_pc_q     <= head.pc;
                            flush_q     <= 1'b1;
                            flush_pc_q  <= head.pc;
                            state_q     <= FLUSH;
                        end else begin
                            case (head.fu)
                                FU_STORE: begin
                                    if (!bus.commit_lsu_ready_i) begin
                                        state_q <= STORE_WAIT;
                                    end
                                end
                                // CSR side effects and fences require refetching the next instruction.
                                FU_CSR, FU_FENCE: begin
                                    flush_q    <= 1'b1;
                                    flush_pc_q <= head.pc + XLEN'(4);
                                    state_q    <= FLUSH;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                STORE_WAIT: begin
                    if (bus.commit_lsu_ready_i) begin
                        state_q <= RUN;
                    end
                end
                FLUSH: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign bus.commit_ack_o = ack;
    assign bus.we_gpr_o     = we_gpr;
    assign bus.waddr_o      = waddr;
    assign bus.wdata_o      = wdata;
    assign bus.commit_lsu_o = lsu_commit;
    assign bus.csr_commit_o = csr_commit;
    assign bus.exception_o  = exception_q;
    assign bus.ex_cause_o   = ex_cause_q;
    assign bus.ex_tval_o    = ex_tval_q;
    assign bus.ex_pc_o      = ex_pc_q;
    assign bus.flush_o      = flush_q && !rst_i;
    assign bus.flush_pc_o   = flush_pc_q;
    assign bus.instret_o    = instret_q;

endmodule

// File: tb/tb_commit_stage.sv
// Self-checking bench for commit_stage: directed scenarios followed by random head streams,
// all compared each cycle against a transaction-level retirement model.
module tb_commit_stage;
    import config_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    commit_stage_if bus ();

    commit_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Retirement model: what the pipeline owes the outside world in the next cycle.
    bit          m_flush_pending;
    logic [63:0] m_flush_pc;
    bit          m_store_pending;
    bit          m_exc;
    logic [63:0] m_cause;
    logic [63:0] m_tval;
    logic [63:0] m_ex_pc;
    logic [63:0] m_instret;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_flush_pending = 1'b0;
        m_flush_pc      = '0;
        m_store_pending = 1'b0;
        m_exc           = 1'b0;
        m_cause         = '0;
        m_tval          = '0;
        m_ex_pc         = '0;
        m_instret       = '0;
    endtask

    // Inputs are already applied at the falling edge; check just after, then advance the model across the rising edge.
    task automatic run_cycle();
        scoreboard_entry_t h;
        bit          takes_head;
        bit          e_ack, e_we, e_lsu, e_csr;
        logic [4:0]  e_waddr;
        logic [63:0] e_wdata;
        #1;
        h       = bus.commit_instr_i;
        e_ack   = 0; e_we = 0; e_lsu = 0; e_csr = 0;
        e_waddr = '0;
        e_wdata = '0;
        takes_head = !rst && !m_flush_pending && !m_store_pending && h.valid && !bus.halt_i;

        if (!rst && !m_flush_pending && m_store_pending) begin
            e_lsu = 1;
            e_ack = bus.commit_lsu_ready_i;
        end else if (takes_head) begin
            if (h.ex.valid) begin
                e_ack = 1;
            end else begin
                case (h.fu)
                    FU_STORE: begin e_lsu = 1; e_ack = bus.commit_lsu_ready_i; end
                    FU_CSR:   begin e_csr = 1; e_ack = 1; e_we = (h.rd != 0); e_wdata = bus.csr_rdata_i; end
                    FU_FENCE: e_ack = 1;
                    default:  begin e_ack = 1; e_we = (h.rd != 0); e_wdata = h.result; end
                endcase
            end
            if (e_we) e_waddr = h.rd;
            else      e_wdata = '0;
        end

        check("ack",       64'(bus.commit_ack_o), 64'(e_ack));
        check("we_gpr",    64'(bus.we_gpr_o),     64'(e_we));
        check("waddr",     64'(bus.waddr_o),      64'(e_waddr));
        check("wdata",     bus.wdata_o,           e_wdata);
        check("lsu",       64'(bus.commit_lsu_o), 64'(e_lsu));
        check("csr",       64'(bus.csr_commit_o), 64'(e_csr));
        check("exception", 64'(bus.exception_o),  64'(m_exc));
        check("ex_cause",  bus.ex_cause_o,        m_cause);
        check("ex_tval",   bus.ex_tval_o,         m_tval);
        check("ex_pc",     bus.ex_pc_o,           m_ex_pc);
        check("flush",     64'(bus.flush_o),      64'(m_flush_pending && !rst));
        check("flush_pc",  bus.flush_pc_o,        m_flush_pc);
        check("instret",   bus.instret_o,         m_instret);

        if (rst) begin
            model_reset();
        end else begin
            m_exc = takes_head && h.ex.valid;
            if (m_exc) begin
                m_cause = h.ex.cause;
                m_tval  = h.ex.tval;
                m_ex_pc = h.pc;
            end
            if (takes_head && (h.ex.valid || h.fu == FU_CSR || h.fu == FU_FENCE)) begin
                m_flush_pending = 1'b1;
                m_flush_pc      = h.ex.valid ? h.pc : h.pc + 64'd4;
            end else begin
                m_flush_pending = 1'b0;
            end
            m_store_pending = e_lsu && !bus.commit_lsu_ready_i;
            if (e_ack && !h.ex.valid) m_instret = m_instret + 64'd1;
        end
        @(negedge clk);
    endtask

    function automatic scoreboard_entry_t make_entry(input fu_t fu, input logic [4:0] rd,
                                                     input logic [63:0] pc, input logic [63:0] result);
        scoreboard_entry_t e;
        e          = '0;
        e.valid    = 1'b1;
        e.fu       = fu;
        e.rd       = rd;
        e.pc       = pc;
        e.result   = result;
        return e;
    endfunction

    task automatic idle_cycle();
        bus.commit_instr_i     = '0;
        bus.halt_i             = 1'b0;
        bus.commit_lsu_ready_i = 1'b0;
        run_cycle();
    endtask

    initial begin
        scoreboard_entry_t e;
        checks = 0;
        errors = 0;
        rst                    = 1'b1;
        bus.halt_i             = 1'b0;
        bus.commit_instr_i     = '0;
        bus.commit_lsu_ready_i = 1'b0;
        bus.csr_rdata_i        = '0;
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        // Reset state.
        idle_cycle();

        // ALU writes rd=5, then rd=0 retires without a write.
        bus.commit_instr_i = make_entry(FU_ALU, 5'd5, 64'h40, 64'hDEAD);
        run_cycle();
        bus.commit_instr_i = make_entry(FU_ALU, 5'd0, 64'h44, 64'h1234);
        run_cycle();
        idle_cycle();

        // Store stalled three cycles by the store buffer, then accepted.
        bus.commit_instr_i = make_entry(FU_STORE, 5'd0, 64'h48, 64'h0);
        for (int i = 0; i < 3; i++) run_cycle();
        bus.commit_lsu_ready_i = 1'b1;
        run_cycle();
        idle_cycle();

        // CSR with old value written back, followed by a flush to pc+4.
        bus.commit_instr_i = make_entry(FU_CSR, 5'd3, 64'h8000_0000, 64'h0);
        bus.csr_rdata_i    = 64'h1800;
        run_cycle();
        run_cycle();
        idle_cycle();

        // Excepting entry: ack without side effects, trap and flush together.
        e              = make_entry(FU_LOAD, 5'd7, 64'h100, 64'h55);
        e.ex.valid     = 1'b1;
        e.ex.cause     = 64'd2;
        e.ex.tval      = 64'hBAD0;
        bus.commit_instr_i = e;
        run_cycle();
        run_cycle();
        idle_cycle();

        // Reset while a store waits.
        bus.commit_instr_i = make_entry(FU_STORE, 5'd0, 64'h200, 64'h0);
        run_cycle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        bus.commit_instr_i = '0;
        run_cycle();

        // Halt blocks a valid head.
        bus.halt_i         = 1'b1;
        bus.commit_instr_i = make_entry(FU_ALU, 5'd9, 64'h300, 64'h77);
        run_cycle();
        bus.halt_i = 1'b0;
        run_cycle();

        // Random head stream; a stalled store head stays put as the scoreboard would hold it.
        for (int n = 0; n < 3000; n++) begin
            if (!m_store_pending || rst) begin
                e          = '0;
                e.valid    = ($urandom_range(0, 9) < 8);
                e.fu       = fu_t'($urandom_range(0, 6));
                e.rd       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                e.pc       = {$urandom, $urandom};
                e.result   = {$urandom, $urandom};
                e.ex.valid = ($urandom_range(0, 9) == 0);
                e.ex.cause = 64'($urandom_range(0, 15));
                e.ex.tval  = {$urandom, $urandom};
                bus.commit_instr_i = e;
            end
            bus.halt_i             = ($urandom_range(0, 9) == 0);
            bus.commit_lsu_ready_i = $urandom_range(0, 1) != 0;
            bus.csr_rdata_i        = {$urandom, $urandom};
            rst                    = ($urandom_range(0, 99) < 2);
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
